lc3_control_unit: RTL and testbench

- Instruction sequencer (control FSM) for the LC-3 datapath. Sits directly upstream of the datapath and drives every load, gate and mux-select the datapath consumes.
- Runs fetch, decode and execute for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE.
- Reads IR and BEN back from the datapath, and sequences multi-cycle SRAM reads and writes.

---
 rtl/lc3_control_unit.sv | 257 +++++++++++++++++++++++++
 tb/tb_lc3_control_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_control_unit.sv
// LC-3 control sequencer: fetch/decode/execute FSM driving the datapath's loads, gates and mux selects.
// Outputs are registered from the next state, so they behave as Moore outputs of the current state.
module lc3_control_unit #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_LED,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic [1:0]  ADDR2MUX,
    output logic        ADDR1MUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        DRMUX,
    output logic        MARMUX,
    output logic [1:0]  ALUK,
    output logic        MIO_EN,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [4:0]  State
);

    localparam int unsigned CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT);

    // Debug codes follow the LC-3 state numbers where they fit in 5 bits; HALTED is 0.
    typedef enum logic [4:0] {
        S_HALTED = 5'd0,
        S_01     = 5'd1,
        S_04     = 5'd4,
        S_05     = 5'd5,
        S_06     = 5'd6,
        S_07     = 5'd7,
        S_09     = 5'd9,
        S_12     = 5'd12,
        S_13     = 5'd13,
        S_13B    = 5'd14,
        S_16     = 5'd16,
        S_18     = 5'd18,
        S_21     = 5'd21,
        S_22     = 5'd22,
        S_23     = 5'd23,
        S_00     = 5'd24,
        S_25     = 5'd25,
        S_27     = 5'd27,
        S_32     = 5'd29,
        S_33     = 5'd30,
        S_35     = 5'd31
    } state_e;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic [1:0] addr2mux;
        logic       addr1mux;
        logic       sr1mux;
        logic       sr2mux;
        logic       drmux;
        logic       marmux;
        logic [1:0] aluk;
        logic       mio_en;
        logic       mem_oe;
        logic       mem_we;
    } ctl_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctl_t             ctl_q, ctl_d;
    logic             mem_last;
    logic             mem_state;
    logic             unused_ir;

    assign mem_last  = (cnt_q == CNT_LAST);
    assign mem_state = (state_q == S_33) || (state_q == S_25) || (state_q == S_16);
    assign unused_ir = ^{IR[11:6], IR[4:0]};

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALTED: if (Run) state_d = S_18;
            S_18:     state_d = S_33;
            S_33:     if (mem_last) state_d = S_35;
            S_35:     state_d = S_32;
            S_32: begin
                case (IR[15:12])
                    4'b0001: state_d = S_01;
                    4'b0101: state_d = S_05;
                    4'b1001: state_d = S_09;
                    4'b0000: state_d = S_00;
                    4'b1100: state_d = S_12;
                    4'b0100: state_d = S_04;
                    4'b0110: state_d = S_06;
                    4'b0111: state_d = S_07;
                    4'b1101: state_d = S_13;
                    default: state_d = S_18;
                endcase
            end
            S_01, S_05, S_09, S_22, S_12, S_21, S_27: state_d = S_18;
            S_00:     state_d = BEN ? S_22 : S_18;
            S_04:     state_d = S_21;
            S_06:     state_d = S_25;
            S_25:     if (mem_last) state_d = S_27;
            S_07:     state_d = S_23;
            S_23:     state_d = S_16;
            S_16:     if (mem_last) state_d = S_18;
            S_13:     if (Continue) state_d = S_13B;
            S_13B:    if (!Continue) state_d = S_18;
            default:  state_d = S_HALTED;
        endcase
    end

    // Wait counter restarts on every entry into a memory state and saturates at MEM_WAIT
    always_comb begin
        cnt_d = '0;
        if (mem_state && (state_d == state_q)) begin
            cnt_d = mem_last ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    // Control word for the state being entered
    always_comb begin
        ctl_d = '0;
        case (state_d)
            S_18: begin
                ctl_d.gate_pc = 1'b1;
                ctl_d.ld_mar  = 1'b1;
                ctl_d.ld_pc   = 1'b1;
            end
            S_33, S_25: begin
                ctl_d.mio_en = 1'b1;
                ctl_d.mem_oe = 1'b1;
                ctl_d.ld_mdr = (cnt_d == CNT_LAST);
            end
            S_35: begin
                ctl_d.gate_mdr = 1'b1;
                ctl_d.ld_ir    = 1'b1;
            end
            S_32: ctl_d.ld_ben = 1'b1;
            S_01, S_05, S_09: begin
                ctl_d.sr1mux   = 1'b1;
                ctl_d.gate_alu = 1'b1;
                ctl_d.ld_reg   = 1'b1;
                ctl_d.ld_cc    = 1'b1;
                ctl_d.sr2mux   = (state_d == S_09) ? 1'b0 : IR[5];
                ctl_d.aluk     = (state_d == S_01) ? 2'b00 :
                                 (state_d == S_05) ? 2'b01 : 2'b10;
            end
            S_22: begin
                ctl_d.addr2mux = 2'b10;
                ctl_d.pcmux    = 2'b10;
                ctl_d.ld_pc    = 1'b1;
            end
            S_12: begin
                ctl_d.sr1mux   = 1'b1;
                ctl_d.aluk     = 2'b11;
                ctl_d.gate_alu = 1'b1;
                ctl_d.pcmux    = 2'b01;
                ctl_d.ld_pc    = 1'b1;
            end
            S_04: begin
                ctl_d.gate_pc = 1'b1;
                ctl_d.drmux   = 1'b1;
                ctl_d.ld_reg  = 1'b1;
            end
            S_21: begin
                ctl_d.addr2mux = 2'b11;
                ctl_d.pcmux    = 2'b10;
                ctl_d.ld_pc    = 1'b1;
            end
            S_06, S_07: begin
                ctl_d.sr1mux      = 1'b1;
                ctl_d.addr1mux    = 1'b1;
                ctl_d.addr2mux    = 2'b01;
                ctl_d.gate_marmux = 1'b1;
                ctl_d.ld_mar      = 1'b1;
            end
            S_27: begin
                ctl_d.gate_mdr = 1'b1;
                ctl_d.ld_reg   = 1'b1;
                ctl_d.ld_cc    = 1'b1;
            end
            S_23: begin
                ctl_d.aluk     = 2'b11;
                ctl_d.gate_alu = 1'b1;
                ctl_d.ld_mdr   = 1'b1;
            end
            S_16: ctl_d.mem_we = 1'b1;
            S_13: ctl_d.ld_led = (state_q != S_13);
            default: ctl_d = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_HALTED;
            cnt_q   <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
        end
    end

    assign LD_MAR     = ctl_q.ld_mar;
    assign LD_MDR     = ctl_q.ld_mdr;
    assign LD_IR      = ctl_q.ld_ir;
    assign LD_BEN     = ctl_q.ld_ben;
    assign LD_CC      = ctl_q.ld_cc;
    assign LD_REG     = ctl_q.ld_reg;
    assign LD_PC      = ctl_q.ld_pc;
    assign LD_LED     = ctl_q.ld_led;
    assign GatePC     = ctl_q.gate_pc;
    assign GateMDR    = ctl_q.gate_mdr;
    assign GateALU    = ctl_q.gate_alu;
    assign GateMARMUX = ctl_q.gate_marmux;
    assign PCMUX      = ctl_q.pcmux;
    assign ADDR2MUX   = ctl_q.addr2mux;
    assign ADDR1MUX   = ctl_q.addr1mux;
    assign SR1MUX     = ctl_q.sr1mux;
    assign SR2MUX     = ctl_q.sr2mux;
    assign DRMUX      = ctl_q.drmux;
    assign MARMUX     = ctl_q.marmux;
    assign ALUK       = ctl_q.aluk;
    assign MIO_EN     = ctl_q.mio_en;
    assign Mem_OE     = ctl_q.mem_oe;
    assign Mem_WE     = ctl_q.mem_we;
    assign State      = state_q;

endmodule

// File: tb/tb_lc3_control_unit.sv
// Bench for lc3_control_unit: expands each instruction into its expected per-cycle state/control trace.
module tb_lc3_control_unit;

    localparam int unsigned W = 2;

    localparam logic [4:0] ST_HALTED = 5'd0,  ST_01 = 5'd1,  ST_04 = 5'd4,  ST_05 = 5'd5,
                           ST_06 = 5'd6,  ST_07 = 5'd7,  ST_09 = 5'd9,  ST_12 = 5'd12,
                           ST_13 = 5'd13, ST_13B = 5'd14, ST_16 = 5'd16, ST_18 = 5'd18,
                           ST_21 = 5'd21, ST_22 = 5'd22, ST_23 = 5'd23, ST_00 = 5'd24,
                           ST_25 = 5'd25, ST_27 = 5'd27, ST_32 = 5'd29, ST_33 = 5'd30,
                           ST_35 = 5'd31;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux;
        logic       addr1mux, sr1mux, sr2mux, drmux, marmux;
        logic [1:0] aluk;
        logic       mio_en, mem_oe, mem_we;
    } ctl_t;

    typedef struct packed {
        logic [4:0] st;
        ctl_t       c;
    } step_t;

    logic        Clk = 1'b0;
    logic        Reset_n, Run, Continue, BEN;
    logic [15:0] IR;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        ADDR1MUX, SR1MUX, SR2MUX, DRMUX, MARMUX, MIO_EN, Mem_OE, Mem_WE;
    logic [4:0]  State;

    int    checks = 0;
    int    failures = 0;
    step_t exp_q[$];

    lc3_control_unit #(.MEM_WAIT(W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .IR(IR), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED), .GatePC(GatePC), .GateMDR(GateMDR),
        .GateALU(GateALU), .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
        .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .DRMUX(DRMUX), .MARMUX(MARMUX),
        .ALUK(ALUK), .MIO_EN(MIO_EN), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .State(State)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic ctl_t actual();
        ctl_t c;
        c = '0;
        c.ld_mar = LD_MAR;   c.ld_mdr = LD_MDR;     c.ld_ir = LD_IR;       c.ld_ben = LD_BEN;
        c.ld_cc = LD_CC;     c.ld_reg = LD_REG;     c.ld_pc = LD_PC;       c.ld_led = LD_LED;
        c.gate_pc = GatePC;  c.gate_mdr = GateMDR;  c.gate_alu = GateALU;  c.gate_marmux = GateMARMUX;
        c.pcmux = PCMUX;     c.addr2mux = ADDR2MUX; c.addr1mux = ADDR1MUX; c.sr1mux = SR1MUX;
        c.sr2mux = SR2MUX;   c.drmux = DRMUX;       c.marmux = MARMUX;     c.aluk = ALUK;
        c.mio_en = MIO_EN;   c.mem_oe = Mem_OE;     c.mem_we = Mem_WE;
        return c;
    endfunction

    function automatic void push(input logic [4:0] st, input ctl_t c);
        step_t s;
        s.st = st;
        s.c  = c;
        exp_q.push_back(s);
    endfunction

    function automatic ctl_t fetch_ctl();
        ctl_t c = '0;
        c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1;
        return c;
    endfunction

    // A memory access spends W+1 cycles in one state; only the final read cycle loads MDR.
    function automatic void push_access(input logic [4:0] st, input logic is_write);
        ctl_t c;
        for (int k = 0; k <= int'(W); k++) begin
            c = '0;
            if (is_write) c.mem_we = 1'b1;
            else begin
                c.mio_en = 1'b1; c.mem_oe = 1'b1; c.ld_mdr = (k == int'(W));
            end
            push(st, c);
        end
    endfunction

    // Cycles after S18: read, load IR, decode.
    function automatic void model_fetch();
        ctl_t c;
        push_access(ST_33, 1'b0);
        c = '0; c.gate_mdr = 1'b1; c.ld_ir = 1'b1; push(ST_35, c);
        c = '0; c.ld_ben = 1'b1; push(ST_32, c);
    endfunction

    // Full trace from the cycle after S18 to the next S18.
    function automatic void model_instr(input logic [15:0] ir, input logic ben);
        ctl_t c;
        model_fetch();
        c = '0;
        case (ir[15:12])
            4'h1, 4'h5, 4'h9: begin
                c.sr1mux = 1'b1; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                if (ir[15:12] == 4'h1) begin c.aluk = 2'b00; c.sr2mux = ir[5]; push(ST_01, c); end
                else if (ir[15:12] == 4'h5) begin c.aluk = 2'b01; c.sr2mux = ir[5]; push(ST_05, c); end
                else begin c.aluk = 2'b10; push(ST_09, c); end
            end
            4'h0: begin
                push(ST_00, c);
                if (ben) begin c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1'b1; push(ST_22, c); end
            end
            4'hC: begin
                c.sr1mux = 1'b1; c.aluk = 2'b11; c.gate_alu = 1'b1; c.pcmux = 2'b01; c.ld_pc = 1'b1;
                push(ST_12, c);
            end
            4'h4: begin
                c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; push(ST_04, c);
                c = '0; c.addr2mux = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1'b1; push(ST_21, c);
            end
            4'h6, 4'h7: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b01; c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
                if (ir[15:12] == 4'h6) begin
                    push(ST_06, c);
                    push_access(ST_25, 1'b0);
                    c = '0; c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; push(ST_27, c);
                end else begin
                    push(ST_07, c);
                    c = '0; c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; push(ST_23, c);
                    push_access(ST_16, 1'b1);
                end
            end
            default: ;
        endcase
        push(ST_18, fetch_ctl());
    endfunction

    task automatic test_reset();
        Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0; IR = 16'h0000; BEN = 1'b0;
        #2;
        checks++;
        if (State !== ST_HALTED || actual() !== ctl_t'(0)) begin
            failures++;
            $display("FAIL reset_async state=%0d ctl=%h required state=%0d ctl=0", State, actual(), ST_HALTED);
        end
        step();
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (State !== ST_HALTED || actual() !== ctl_t'(0)) begin
                failures++;
                $display("FAIL halted_idle state=%0d ctl=%h required state=%0d ctl=0", State, actual(), ST_HALTED);
            end
        end
        Run = 1'b1;
        step();
        Run = 1'b0;
        checks++;
        if (State !== ST_18 || actual() !== fetch_ctl()) begin
            failures++;
            $display("FAIL run_start state=%0d ctl=%h required state=%0d ctl=%h", State, actual(), ST_18, fetch_ctl());
        end
    endtask

    // Directed instructions followed by random ones; Run/Continue toggle randomly and must be ignored.
    task automatic test_instructions(input int n_random);
        logic [15:0] dir_ir [10] = '{16'h1263, 16'h1243, 16'h5042, 16'h927F, 16'h0E05,
                                     16'h0E05, 16'h6283, 16'h7283, 16'hC1C0, 16'h8000};
        logic        dir_ben [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] r;
        step_t       e;
        ctl_t        a;
        for (int n = 0; n < 10 + n_random; n++) begin
            if (n < 10) begin
                IR = dir_ir[n]; BEN = dir_ben[n];
            end else begin
                r = $urandom();
                IR = r[15:0];
                if (IR[15:12] == 4'hD) IR[15:12] = 4'h8;
                BEN = r[16];
            end
            model_instr(IR, BEN);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                step();
                r = $urandom();
                Run = r[0]; Continue = r[1];
                a = actual();
                checks++;
                if (State !== e.st || a !== e.c) begin
                    failures++;
                    $display("FAIL instr ir=%h ben=%0b state=%0d ctl=%h required state=%0d ctl=%h",
                             IR, BEN, State, a, e.st, e.c);
                end
            end
        end
        Run = 1'b0; Continue = 1'b0;
    endtask

    task automatic test_pause();
        step_t e;
        ctl_t  c;
        IR = 16'hD0AA; BEN = 1'b0; Continue = 1'b0;
        model_fetch();
        c = '0; c.ld_led = 1'b1; push(ST_13, c);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            checks++;
            if (State !== e.st || actual() !== e.c) begin
                failures++;
                $display("FAIL pause_entry state=%0d ctl=%h required state=%0d ctl=%h", State, actual(), e.st, e.c);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (State !== ST_13 || actual() !== ctl_t'(0)) begin
                failures++;
                $display("FAIL pause_hold state=%0d ctl=%h required state=%0d ctl=0", State, actual(), ST_13);
            end
        end
        Continue = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (State !== ST_13B || actual() !== ctl_t'(0)) begin
                failures++;
                $display("FAIL pause_phase2 state=%0d ctl=%h required state=%0d ctl=0", State, actual(), ST_13B);
            end
        end
        Continue = 1'b0;
        step();
        checks++;
        if (State !== ST_18 || actual() !== fetch_ctl()) begin
            failures++;
            $display("FAIL pause_release state=%0d ctl=%h required state=%0d ctl=%h", State, actual(), ST_18, fetch_ctl());
        end
    endtask

    task automatic test_reset_mid_access();
        step_t e;
        ctl_t  c;
        IR = 16'h1263; BEN = 1'b0;
        step();
        c = '0; c.mio_en = 1'b1; c.mem_oe = 1'b1;
        checks++;
        if (State !== ST_33 || actual() !== c) begin
            failures++;
            $display("FAIL midreset_pre state=%0d ctl=%h required state=%0d ctl=%h", State, actual(), ST_33, c);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (State !== ST_HALTED || actual() !== ctl_t'(0)) begin
            failures++;
            $display("FAIL midreset_async state=%0d ctl=%h required state=%0d ctl=0", State, actual(), ST_HALTED);
        end
        step();
        Reset_n = 1'b1; Run = 1'b0;
        step();
        checks++;
        if (State !== ST_HALTED || actual() !== ctl_t'(0)) begin
            failures++;
            $display("FAIL midreset_halt state=%0d ctl=%h required state=%0d ctl=0", State, actual(), ST_HALTED);
        end
        Run = 1'b1;
        step();
        Run = 1'b0;
        checks++;
        if (State !== ST_18 || actual() !== fetch_ctl()) begin
            failures++;
            $display("FAIL midreset_run state=%0d ctl=%h required state=%0d ctl=%h", State, actual(), ST_18, fetch_ctl());
        end
        model_instr(IR, BEN);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            checks++;
            if (State !== e.st || actual() !== e.c) begin
                failures++;
                $display("FAIL midreset_refetch state=%0d ctl=%h required state=%0d ctl=%h", State, actual(), e.st, e.c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_instructions(40);
        test_pause();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
